// File: rtl/rdc_pkg.sv
// Shared definitions for the read-data collector: beat/burst widths, host chunking
// and the tag encoding stored in the outstanding-read FIFO.
package rdc_pkg;

    localparam logic TAG_HOST = 1'b0;
    localparam logic TAG_PR   = 1'b1;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_e;

    function automatic int beat_width(input int dq_width);
        return 4 * dq_width;
    endfunction

    function automatic int burst_width(input int dq_width);
        return 8 * dq_width;
    endfunction

    function automatic int nchunk(input int dq_width, input int host_width);
        return (8 * dq_width) / host_width;
    endfunction

    // Index width that stays legal when there is only one chunk.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_data_collector_if.sv
// Host return path of the read-data collector, plus the output FSM state for observation.
// Handshake: a chunk transfers on a clock edge where host_valid && host_ready; while host_valid
// is high and host_ready low, host_data and host_last hold steady and host_valid stays high.
interface rd_data_collector_if #(
    parameter int HOST_WIDTH = 256
);
    import rdc_pkg::*;

    logic                  host_valid;
    logic [HOST_WIDTH-1:0] host_data;
    logic                  host_last;
    logic                  host_ready;
    out_state_e            state_dbg;

    modport master (
        output host_valid,
        output host_data,
        output host_last,
        output state_dbg,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        input  host_last,
        input  state_dbg,
        output host_ready
    );

endinterface

// File: rtl/rdc_tag_fifo.sv
// Outstanding-read tag FIFO: 1-bit entries, registered full/empty, push and pop in one
// cycle keep occupancy unchanged (a push at full is accepted only alongside a pop).
module rdc_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full_q || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/rd_data_collector.sv
// Pairs dispatcher read issues with PHY read bursts; host bursts stream out in chunks,
// periodic bursts go to pr_done/pr_data. Optional counters: RD_COLLECTOR_STATS_EN.
module rd_data_collector
    import rdc_pkg::*;
#(
    parameter int DQ_WIDTH   = 64,
    parameter int HOST_WIDTH = 256,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_issue,
    input  logic                  rd_issue_pr,
    input  logic                  dfi_rddata_valid,
    input  logic [4*DQ_WIDTH-1:0] dfi_rddata,
    rd_data_collector_if.master   host,
    output logic                  pr_done,
    output logic [8*DQ_WIDTH-1:0] pr_data,
    output logic                  tag_full,
    output logic                  err_overflow,
    output logic                  err_notag,
    input  logic                  err_clr
`ifdef RD_COLLECTOR_STATS_EN
    ,
    output logic [31:0]           stat_host_cnt,
    output logic [31:0]           stat_pr_cnt,
    output logic [31:0]           stat_drop_cnt
`endif
);
    localparam int BEAT_W  = beat_width(DQ_WIDTH);
    localparam int BURST_W = burst_width(DQ_WIDTH);
    localparam int NCHUNK  = nchunk(DQ_WIDTH, HOST_WIDTH);
    localparam int KW      = idx_width(NCHUNK);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    // Beat assembly
    logic               beat_q;
    logic [BEAT_W-1:0]  lo_q;
    logic               burst_done;
    logic [BURST_W-1:0] burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= 1'b0;
            lo_q   <= '0;
        end else if (dfi_rddata_valid) begin
            beat_q <= ~beat_q;
            if (!beat_q) lo_q <= dfi_rddata;
        end
    end

    assign burst_done = dfi_rddata_valid && beat_q;
    assign burst      = {dfi_rddata, lo_q};

    // Tag FIFO and routing
    logic head_tag;
    logic fifo_empty;
    logic fifo_full;
    logic route_pr;
    logic route_host;

    rdc_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_issue),
        .push_data (rd_issue_pr),
        .pop       (burst_done),
        .pop_data  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tag_full = fifo_full;

    // A burst with no tag available is treated as a host read.
    assign route_pr   = burst_done && !fifo_empty && (head_tag == TAG_PR);
    assign route_host = burst_done && !route_pr;

    // Output FSM
    out_state_e                         state_q;
    out_state_e                         state_d;
    logic [KW-1:0]                      k_q;
    logic [KW-1:0]                      k_d;
    logic [NCHUNK-1:0][HOST_WIDTH-1:0]  buf_q;
    logic                               chunk_accept;
    logic                               last_accept;
    logic                               buf_free;
    logic                               host_load;
    logic                               host_drop;

    assign chunk_accept = (state_q == OUT_SEND) && host.host_ready;
    assign last_accept  = chunk_accept && (k_q == K_LAST);
    // The buffer frees up in the same cycle its last chunk is taken.
    assign buf_free     = (state_q == OUT_IDLE) || last_accept;
    assign host_load    = route_host && buf_free;
    assign host_drop    = route_host && !buf_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OUT_IDLE;
            k_q     <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (host_load) buf_q <= burst;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            OUT_IDLE: begin
                if (host_load) begin
                    state_d = OUT_SEND;
                    k_d     = '0;
                end
            end
            OUT_SEND: begin
                if (chunk_accept) begin
                    if (k_q == K_LAST) begin
                        state_d = host_load ? OUT_SEND : OUT_IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = OUT_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_comb begin
        host.host_valid = 1'b0;
        host.host_last  = 1'b0;
        host.host_data  = '0;
        host.state_dbg  = state_q;
        if (state_q == OUT_SEND) begin
            host.host_valid = 1'b1;
            host.host_last  = (k_q == K_LAST);
            host.host_data  = buf_q[k_q];
        end
    end

    // Periodic-read delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            pr_done <= 1'b0;
            pr_data <= '0;
        end else begin
            pr_done <= route_pr;
            if (route_pr) pr_data <= burst;
        end
    end

    // Sticky errors; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow <= 1'b0;
            err_notag    <= 1'b0;
        end else if (err_clr) begin
            err_overflow <= 1'b0;
            err_notag    <= 1'b0;
        end else begin
            if (host_drop)                 err_overflow <= 1'b1;
            if (burst_done && fifo_empty)  err_notag    <= 1'b1;
        end
    end

`ifdef RD_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            stat_host_cnt <= '0;
            stat_pr_cnt   <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (last_accept && (stat_host_cnt != 32'hFFFF_FFFF)) stat_host_cnt <= stat_host_cnt + 32'd1;
            if (route_pr    && (stat_pr_cnt   != 32'hFFFF_FFFF)) stat_pr_cnt   <= stat_pr_cnt + 32'd1;
            if (host_drop   && (stat_drop_cnt != 32'hFFFF_FFFF)) stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`endif

endmodule
